// File: rtl/line_burst_memory_if.sv
// Cache-to-backing-store bus: one request/response channel carrying line
// fills (read bursts) and dirty-line writebacks (write bursts).
interface line_burst_memory_if #(
    parameter int ADDRBITS  = 32,
    parameter int WORDBITS  = 32,
    parameter int LINEITEMS = 16
);
    logic                         request;
    logic                         rw;
    logic [ADDRBITS-1:0]          addr;
    logic [WORDBITS-1:0]          wdata;
    logic                         wvalid;
    logic                         busy;
    logic [WORDBITS-1:0]          rdata;
    logic                         valid;
    logic [$clog2(LINEITEMS)-1:0] beat;
    logic                         done;

    // cache side
    modport master (
        output request, rw, addr, wdata, wvalid,
        input  busy, rdata, valid, beat, done
    );

    // memory side
    modport slave (
        input  request, rw, addr, wdata, wvalid,
        output busy, rdata, valid, beat, done
    );
endinterface

// File: rtl/line_burst_memory.sv
// Line-granular backing store. Fills stream a whole line one word per beat
// after LATENCY wait cycles; writebacks take one word per wvalid beat and
// then spend LATENCY cycles committing before done. One transaction at a time.
module line_burst_memory #(
    parameter int ADDRBITS    = 32,
    parameter int WORDBITS    = 32,
    parameter int LINEITEMS   = 16,
    parameter int DEPTH_LINES = 256,
    parameter int LATENCY     = 8
) (
    input  logic                clock,
    input  logic                reset,
    line_burst_memory_if.slave  bus
);
    localparam int BEATBITS = $clog2(LINEITEMS);
    localparam int LINEBITS = $clog2(DEPTH_LINES);
    localparam int OFF      = BEATBITS + $clog2(WORDBITS/8);
    localparam int CNTBITS  = $clog2(LATENCY + 1);
    localparam logic [BEATBITS-1:0] LAST_BEAT = BEATBITS'(LINEITEMS - 1);
    localparam logic [CNTBITS-1:0]  WAIT_LOAD = CNTBITS'(LATENCY - 1);

    typedef enum logic [2:0] {IDLE, WAIT, READ_BURST, WRITE_BURST, DONE} state_t;

    state_t                state_q, state_d;
    logic [LINEBITS-1:0]   line_q;
    logic                  rw_q;
    logic [BEATBITS-1:0]   beat_q, beat_d, rd_beat;
    logic [CNTBITS-1:0]    cnt_q, cnt_d;
    logic [WORDBITS-1:0]   rdata_q;
    logic                  accept, mem_we, rd_en;
    logic                  addr_unused;

    // Storage is flat: {line, beat} selects one word. Zero at power-up, never reset.
    logic [WORDBITS-1:0] mem [DEPTH_LINES*LINEITEMS] = '{default: '0};

    // Only the line-index slice of addr matters; offset and high bits are dropped.
    assign addr_unused = ^bus.addr;

    // Next-state, counters and strobes; rdata is fetched one cycle ahead of its beat.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        mem_we  = 1'b0;
        rd_en   = 1'b0;
        rd_beat = beat_q;
        case (state_q)
            IDLE: begin
                if (bus.request) begin
                    accept = 1'b1;
                    beat_d = '0;
                    if (bus.rw) begin
                        state_d = WRITE_BURST;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WAIT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    if (rw_q) begin
                        state_d = DONE;
                    end else begin
                        state_d = READ_BURST;
                        rd_en   = 1'b1;
                        rd_beat = '0;
                        beat_d  = '0;
                    end
                end else begin
                    cnt_d = cnt_q - CNTBITS'(1);
                end
            end
            READ_BURST: begin
                if (beat_q == LAST_BEAT) begin
                    state_d = DONE;
                end else begin
                    beat_d  = beat_q + BEATBITS'(1);
                    rd_en   = 1'b1;
                    rd_beat = beat_q + BEATBITS'(1);
                end
            end
            WRITE_BURST: begin
                if (bus.wvalid) begin
                    mem_we = 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        // last word taken: beat holds, commit latency follows
                        state_d = WAIT;
                        cnt_d   = WAIT_LOAD;
                    end else begin
                        beat_d = beat_q + BEATBITS'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                beat_d  = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and output registers; reset abandons any burst in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            line_q  <= '0;
            rw_q    <= 1'b0;
            beat_q  <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                line_q <= bus.addr[OFF +: LINEBITS];
                rw_q   <= bus.rw;
            end
            if (rd_en) rdata_q <= mem[{line_q, rd_beat}];
        end
    end

    // Writeback beats land directly in storage.
    always_ff @(posedge clock) begin
        if (mem_we) mem[{line_q, beat_q}] <= bus.wdata;
    end

    assign bus.busy  = (state_q != IDLE);
    assign bus.valid = (state_q == READ_BURST);
    assign bus.done  = (state_q == DONE);
    assign bus.beat  = beat_q;
    assign bus.rdata = rdata_q;
endmodule

// File: tb/tb_line_burst_memory.sv
// Randomized bench for line_burst_memory against a line-array reference model.
module tb_line_burst_memory;
    localparam int ADDRBITS    = 32;
    localparam int WORDBITS    = 32;
    localparam int LINEITEMS   = 16;
    localparam int DEPTH_LINES = 256;
    localparam int LATENCY     = 8;
    localparam int LINEBYTES   = LINEITEMS * WORDBITS / 8;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    line_burst_memory_if #(.ADDRBITS(ADDRBITS), .WORDBITS(WORDBITS), .LINEITEMS(LINEITEMS)) bus ();

    line_burst_memory #(
        .ADDRBITS(ADDRBITS), .WORDBITS(WORDBITS), .LINEITEMS(LINEITEMS),
        .DEPTH_LINES(DEPTH_LINES), .LATENCY(LATENCY)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    logic [WORDBITS-1:0] ref_mem [DEPTH_LINES][LINEITEMS];
    logic [WORDBITS-1:0] wwords [LINEITEMS];
    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int ref_line(input logic [ADDRBITS-1:0] a);
        return int'((a / LINEBYTES) % DEPTH_LINES);
    endfunction

    function automatic logic [ADDRBITS-1:0] mk_addr(input int line, input int hi);
        logic [ADDRBITS-1:0] a;
        a = ADDRBITS'((hi * DEPTH_LINES + line) * LINEBYTES + $urandom_range(0, LINEBYTES - 1));
        return a;
    endfunction

    // Wait for IDLE, present request for one edge, scramble addr afterwards.
    task automatic start_txn(input logic rw, input logic [ADDRBITS-1:0] a);
        int t = 0;
        while (bus.busy && t < 200) begin
            @(posedge clock); #1; t++;
        end
        chk("idle_wait", (t < 200), 1);
        bus.request = 1'b1; bus.rw = rw; bus.addr = a;
        @(posedge clock); #1;
        bus.request = 1'b0; bus.rw = 1'b0; bus.addr = $urandom;
        chk("accept_busy", bus.busy, 1);
    endtask

    // Called one cycle after the accepting edge (cycle 1 of the transaction).
    task automatic read_data(input int line, input bit pulse, input bit hold,
                             input logic [ADDRBITS-1:0] hold_addr);
        int cyc = 1;
        int nv = 0;
        int first = 0;
        int donec = 0;
        while (cyc <= 200) begin
            if (bus.valid) begin
                if (nv == 0) first = cyc;
                if (nv < LINEITEMS) begin
                    chk("rd_beat", bus.beat, nv);
                    chk("rd_data", bus.rdata, ref_mem[line][nv]);
                end
                nv++;
            end
            if (bus.done) begin
                donec = cyc;
                break;
            end
            if (pulse && nv == 5) begin
                bus.request = 1'b1; bus.rw = 1'b1;
            end else if (pulse) begin
                bus.request = 1'b0; bus.rw = 1'b0;
            end
            @(posedge clock); #1; cyc++;
        end
        chk("rd_first_cycle", first, LATENCY + 1);
        chk("rd_beats", nv, LINEITEMS);
        chk("rd_done_cycle", donec, LATENCY + LINEITEMS + 1);
        chk("rd_hold", bus.rdata, ref_mem[line][LINEITEMS-1]);
        chk("rd_valid_off", bus.valid, 0);
        if (pulse) begin
            bus.request = 1'b1; bus.rw = 1'b1;
            @(posedge clock); #1;
            bus.request = 1'b0; bus.rw = 1'b0;
            chk("done_req_ignored", bus.busy, 0);
            @(posedge clock); #1;
            chk("req_not_queued", bus.busy, 0);
        end
        if (hold) begin
            bus.request = 1'b1; bus.rw = 1'b0; bus.addr = hold_addr;
            @(posedge clock); #1;
            chk("idle_gap", bus.busy, 0);
            @(posedge clock); #1;
            bus.request = 1'b0; bus.addr = $urandom;
            chk("held_accept", bus.busy, 1);
        end
    endtask

    task automatic do_read(input logic [ADDRBITS-1:0] a);
        start_txn(1'b0, a);
        read_data(ref_line(a), 1'b0, 1'b0, '0);
    endtask

    // mode 0: wvalid continuous, 1: toggling 1,0,1,0, 2: random. abort_after>0 resets mid-burst.
    task automatic do_write(input logic [ADDRBITS-1:0] a, input int mode, input int abort_after);
        int line = ref_line(a);
        int n = 0;
        int t = 0;
        int k = 0;
        logic v;
        start_txn(1'b1, a);
        while (n < LINEITEMS && t < 1000) begin
            v = (mode == 0) ? 1'b1 : (mode == 1) ? ((t % 2) == 0) : 1'($urandom);
            bus.wvalid = v;
            bus.wdata  = v ? wwords[n] : WORDBITS'($urandom);
            @(posedge clock); #1; t++;
            if (v) begin
                ref_mem[line][n] = wwords[n];
                n++;
            end
            if (abort_after > 0 && n == abort_after) begin
                bus.wvalid = 1'b0;
                reset = 1'b0;
                #1;
                chk("rst_busy", bus.busy, 0);
                chk("rst_valid", bus.valid, 0);
                chk("rst_done", bus.done, 0);
                chk("rst_beat", bus.beat, 0);
                chk("rst_rdata", bus.rdata, 0);
                @(negedge clock); reset = 1'b1;
                return;
            end
            if (n < LINEITEMS) begin
                chk("wr_beat", bus.beat, n);
                chk("wr_early_done", bus.done, 0);
            end
        end
        chk("wr_accepted", n, LINEITEMS);
        // stray wvalid during commit must not touch storage
        bus.wvalid = 1'b1; bus.wdata = WORDBITS'($urandom);
        while (k < 100) begin
            @(posedge clock); #1; k++;
            if (bus.done) break;
        end
        bus.wvalid = 1'b0;
        chk("wr_done_cycle", k + 1, LATENCY + 1);
    endtask

    initial begin
        logic [ADDRBITS-1:0] a;
        for (int l = 0; l < DEPTH_LINES; l++)
            for (int b = 0; b < LINEITEMS; b++) ref_mem[l][b] = '0;
        bus.request = 1'b0; bus.rw = 1'b0; bus.addr = '0; bus.wdata = '0; bus.wvalid = 1'b0;
        #1;
        chk("reset_busy", bus.busy, 0);
        chk("reset_valid", bus.valid, 0);
        chk("reset_done", bus.done, 0);
        chk("reset_beat", bus.beat, 0);
        chk("reset_rdata", bus.rdata, 0);
        @(negedge clock); @(negedge clock); reset = 1'b1;

        // power-up line 0 reads as zero
        do_read(mk_addr(0, 0));

        // continuous writeback of 0xA0..0xAF to line 5
        for (int i = 0; i < LINEITEMS; i++) wwords[i] = WORDBITS'(32'hA0 + i);
        do_write(mk_addr(5, 0), 0, 0);
        do_read(mk_addr(5, 0));

        // toggling wvalid
        for (int i = 0; i < LINEITEMS; i++) wwords[i] = WORDBITS'($urandom);
        do_write(mk_addr(9, 0), 1, 0);
        do_read(mk_addr(9, 0));

        // address wrap: line 3 reached through 256+3
        for (int i = 0; i < LINEITEMS; i++) wwords[i] = WORDBITS'($urandom);
        do_write(mk_addr(3, 0), 2, 0);
        a = ADDRBITS'((DEPTH_LINES + 3) * LINEBYTES);
        do_read(a);

        // requests while busy are dropped; a held one is taken after one IDLE cycle
        start_txn(1'b0, mk_addr(5, 1));
        read_data(5, 1'b1, 1'b0, '0);
        start_txn(1'b0, mk_addr(3, 2));
        read_data(3, 1'b0, 1'b1, mk_addr(9, 3));
        read_data(9, 1'b0, 1'b0, '0);

        // reset after 7 writeback beats: partial line survives
        for (int i = 0; i < LINEITEMS; i++) wwords[i] = WORDBITS'($urandom);
        do_write(mk_addr(5, 0), 0, 7);
        do_read(mk_addr(5, 0));

        // random mix over a few lines with random high address bits
        for (int r = 0; r < 10; r++) begin
            a = mk_addr($urandom_range(0, 7), $urandom_range(0, 1000));
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < LINEITEMS; i++) wwords[i] = WORDBITS'($urandom);
                do_write(a, 2, 0);
            end else begin
                do_read(a);
            end
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
